// File: rtl/p17_pkg.sv
// Shared types and constants for the Euler-17 result printer.
package p17_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        SKIP    = 3'd2,
        SEND    = 3'd3,
        NL      = 3'd4,
        FIN     = 3'd5
    } p17_state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Smallest number of decimal digits able to hold 2**width-1.
    function automatic int min_digits(input int width);
        longint unsigned max_val;
        longint unsigned pow10;
        int              d;
        max_val = (64'd1 << width) - 64'd1;
        pow10   = 64'd1;
        d       = 0;
        for (int i = 0; i < 20; i++) begin
            if (pow10 <= max_val) begin
                pow10 = pow10 * 64'd10;
                d     = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: loads on start, then WIDTH add-3/shift steps.
// done is high during the final step, so bcd holds the result one edge later.
module bin2bcd_seq
    import p17_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
    end

    logic [WIDTH-1:0]    shift;
    logic [CNT_W-1:0]    cnt;
    logic [4*DIGITS-1:0] bcd_adj;

    // Add 3 to every nibble that is 5 or more (4-bit add, no carry out).
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift the adjusted {bcd, shift} left once per edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift <= '0;
            bcd   <= '0;
            cnt   <= '0;
        end else if (start) begin
            shift <= bin;
            bcd   <= '0;
            cnt   <= CNT_W'(WIDTH);
        end else if (cnt != '0) begin
            {bcd, shift} <= {bcd_adj[4*DIGITS-2:0], shift, 1'b0};
            cnt          <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);
    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/p17_result_printer.sv
// Prints the letter count as ASCII decimal (leading zeros suppressed, optional LF).
// Byte port: a byte moves on every edge where tx_valid && tx_ready; while tx_valid
// is high and tx_ready low, tx_data and tx_valid hold their values.
module p17_result_printer
    import p17_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int DIGITS       = 5,
    parameter bit EMIT_NEWLINE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done_in,
    input  logic [WIDTH-1:0] value_in,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             finished,
    output logic [2:0]       dbg_state
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

    p17_state_e          state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt, idx_dec;
    logic [7:0]          tx_data_nxt;
    logic                tx_valid_nxt, busy_nxt, finished_nxt;
    logic                done_d;
    logic                trigger, accept;
    logic                conv_busy, conv_done;
    logic [4*DIGITS-1:0] bcd;
    logic [3:0]          nib, nib_dec;

    assign trigger   = done_in && !done_d && (state == IDLE || state == FIN);
    assign accept    = tx_valid && tx_ready;
    assign idx_dec   = idx - IDX_W'(1);
    assign nib       = bcd[{idx, 2'b00} +: 4];
    assign nib_dec   = bcd[{idx_dec, 2'b00} +: 4];
    assign dbg_state = state;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (trigger),
        .bin   (value_in),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = tx_valid;
        busy_nxt     = busy;
        finished_nxt = finished;
        case (state)
            IDLE, FIN: begin
                if (trigger) begin
                    state_nxt    = CONVERT;
                    idx_nxt      = IDX_TOP;
                    tx_valid_nxt = 1'b0;
                    busy_nxt     = 1'b1;
                    finished_nxt = 1'b0;
                end
            end
            CONVERT: begin
                // The idle-converter test only guards against a stuck wait.
                if (conv_done || !conv_busy) begin
                    state_nxt = SKIP;
                end
            end
            SKIP: begin
                if (nib == 4'd0 && idx != '0) begin
                    idx_nxt = idx_dec;
                end else begin
                    state_nxt    = SEND;
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = ASCII_ZERO + {4'h0, nib};
                end
            end
            SEND: begin
                if (accept) begin
                    if (idx != '0) begin
                        idx_nxt     = idx_dec;
                        tx_data_nxt = ASCII_ZERO + {4'h0, nib_dec};
                    end else if (EMIT_NEWLINE) begin
                        state_nxt   = NL;
                        tx_data_nxt = ASCII_LF;
                    end else begin
                        state_nxt    = FIN;
                        tx_valid_nxt = 1'b0;
                        busy_nxt     = 1'b0;
                        finished_nxt = 1'b1;
                    end
                end
            end
            NL: begin
                if (accept) begin
                    state_nxt    = FIN;
                    tx_valid_nxt = 1'b0;
                    busy_nxt     = 1'b0;
                    finished_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                tx_valid_nxt = 1'b0;
                busy_nxt     = 1'b0;
            end
        endcase
    end

    // State and output registers. done_d follows done_in even during reset so
    // a done level held across reset is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        done_d <= done_in;
        if (reset) begin
            state    <= IDLE;
            idx      <= IDX_TOP;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
            busy     <= busy_nxt;
            finished <= finished_nxt;
        end
    end

endmodule

// File: tb/tb_p17_result_printer.sv
// Directed bench for p17_result_printer: one instance with newline, one without,
// both driven by the same inputs; sel picks which one the collector watches.
module tb_p17_result_printer;
    import p17_pkg::*;

    logic        clk = 1'b0;
    logic        reset, done_in, tx_ready, sel;
    logic [15:0] value_in;

    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b, busy_a, busy_b, finished_a, finished_b;
    logic [2:0] state_a, state_b;

    logic [7:0] m_data;
    logic       m_valid, m_busy, m_finished;
    logic [2:0] m_state;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    p17_result_printer #(.WIDTH(16), .DIGITS(5), .EMIT_NEWLINE(1'b1)) dut (
        .clk(clk), .reset(reset), .done_in(done_in), .value_in(value_in),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
        .busy(busy_a), .finished(finished_a), .dbg_state(state_a)
    );

    p17_result_printer #(.WIDTH(16), .DIGITS(5), .EMIT_NEWLINE(1'b0)) dut_nonl (
        .clk(clk), .reset(reset), .done_in(done_in), .value_in(value_in),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
        .busy(busy_b), .finished(finished_b), .dbg_state(state_b)
    );

    assign m_data     = sel ? tx_data_b  : tx_data_a;
    assign m_valid    = sel ? tx_valid_b : tx_valid_a;
    assign m_busy     = sel ? busy_b     : busy_a;
    assign m_finished = sel ? finished_b : finished_a;
    assign m_state    = sel ? state_b    : state_a;

    // Drop done_in for one cycle, then raise it with the value; E0 is the next posedge.
    task automatic trigger(input logic [15:0] v);
        @(negedge clk);
        done_in = 1'b0;
        @(negedge clk);
        value_in = v;
        done_in  = 1'b1;
    endtask

    // Sink: c=0 observes the state after E0. Records accepted bytes and hold violations.
    task automatic collect(input int ready_pct, output int lat, output int stab_err,
                           output logic fin_at_start);
        logic       prev_stall;
        logic [7:0] prev_data;
        lat = -1; stab_err = 0; prev_stall = 1'b0; prev_data = 8'h00;
        fin_at_start = 1'b1;
        got_q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c == 0) fin_at_start = m_finished;
            if (m_valid && lat < 0) lat = c;
            if (prev_stall && (!m_valid || m_data !== prev_data)) stab_err++;
            if (c > 0 && m_finished && !m_busy && !m_valid) break;
            tx_ready   = ($urandom_range(99) < ready_pct);
            prev_stall = m_valid && !tx_ready;
            prev_data  = m_data;
            if (m_valid && tx_ready) got_q.push_back(m_data);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_valid_a !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid_a); else passes++;
        checks++; if (tx_data_a !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data_a); else passes++;
        checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passes++;
        checks++; if (finished_a !== 1'b0) $display("FAIL reset_finished: got %b want 0", finished_a); else passes++;
        checks++; if (state_a !== IDLE) $display("FAIL reset_state: got %0d want %0d", state_a, IDLE); else passes++;
        reset = 1'b0;
    endtask

    task automatic test_print(input string name, input logic [15:0] v, input int ready_pct,
                              input int exp_lat);
        int   lat, stab;
        logic fin0;
        trigger(v);
        collect(ready_pct, lat, stab, fin0);
        if (exp_lat >= 0) begin
            checks++; if (lat !== exp_lat) $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); else passes++;
        end
        checks++; if (fin0 !== 1'b0) $display("FAIL %s_finished_cleared: got %b want 0", name, fin0); else passes++;
        checks++; if (got_q.size() !== exp_q.size()) $display("FAIL %s_byte_count: got %0d want %0d", name, got_q.size(), exp_q.size()); else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) $display("FAIL %s_byte%0d: got none want %h", name, i, exp_q[i]);
            else if (got_q[i] !== exp_q[i]) $display("FAIL %s_byte%0d: got %h want %h", name, i, got_q[i], exp_q[i]);
            else passes++;
        end
        checks++; if (stab !== 0) $display("FAIL %s_hold_stable: got %0d violations want 0", name, stab); else passes++;
        checks++; if (m_finished !== 1'b1) $display("FAIL %s_finished: got %b want 1", name, m_finished); else passes++;
        checks++; if (m_busy !== 1'b0) $display("FAIL %s_busy_end: got %b want 0", name, m_busy); else passes++;
    endtask

    task automatic test_counter_run();
        exp_q = '{8'h32, 8'h31, 8'h31, 8'h32, 8'h34, 8'h0A};
        test_print("run21124", 16'd21124, 100, 17);
    endtask

    task automatic test_zero();
        exp_q = '{8'h30, 8'h0A};
        test_print("zero", 16'd0, 100, 21);
    endtask

    task automatic test_extremes();
        exp_q = '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0A};
        test_print("max65535", 16'd65535, 100, 17);
        exp_q = '{8'h37, 8'h0A};
        test_print("seven", 16'd7, 100, 21);
    endtask

    task automatic test_backpressure();
        exp_q = '{8'h32, 8'h31, 8'h31, 8'h32, 8'h34, 8'h0A};
        test_print("bp30", 16'd21124, 30, 17);
    endtask

    task automatic test_reset_mid_send();
        int accepted = 0;
        int stray = 0;
        trigger(16'd21124);
        tx_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (accepted == 2) break;
            if (tx_valid_a) accepted++;
        end
        checks++; if (state_a !== SEND || tx_valid_a !== 1'b1) $display("FAIL midsend_precond: got state %0d valid %b want %0d 1", state_a, tx_valid_a, SEND); else passes++;
        reset = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk);
        checks++; if (tx_valid_a !== 1'b0) $display("FAIL midsend_tx_valid: got %b want 0", tx_valid_a); else passes++;
        checks++; if (tx_data_a !== 8'h00) $display("FAIL midsend_tx_data: got %h want 00", tx_data_a); else passes++;
        checks++; if (busy_a !== 1'b0 || finished_a !== 1'b0) $display("FAIL midsend_flags: got busy %b fin %b want 0 0", busy_a, finished_a); else passes++;
        checks++; if (state_a !== IDLE) $display("FAIL midsend_state: got %0d want %0d", state_a, IDLE); else passes++;
        reset = 1'b0;
        tx_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tx_valid_a || busy_a) stray++;
        end
        tx_ready = 1'b0;
        checks++; if (stray !== 0) $display("FAIL held_done_no_retrigger: got %0d active cycles want 0", stray); else passes++;
        exp_q = '{8'h32, 8'h31, 8'h31, 8'h32, 8'h34, 8'h0A};
        test_print("rerun", 16'd21124, 100, 17);
    endtask

    task automatic test_no_newline();
        sel = 1'b1;
        checks++; if (finished_b !== 1'b1) $display("FAIL nonl_sticky_before: got %b want 1", finished_b); else passes++;
        exp_q = '{8'h31, 8'h30, 8'h30, 8'h30};
        test_print("nonl1000", 16'd1000, 100, 18);
        sel = 1'b0;
    endtask

    initial begin
        reset = 1'b1; done_in = 1'b0; tx_ready = 1'b0; value_in = 16'd0; sel = 1'b0;
        test_reset();
        test_counter_run();
        test_zero();
        test_extremes();
        test_backpressure();
        test_reset_mid_send();
        test_no_newline();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
